// File: rtl/cell_sweep_pkg.sv
// Shared widths, defaults and FSM state encoding for the cell sweep sequencer.
package cell_sweep_pkg;
    localparam int unsigned PAGE_W = 5;
    localparam int unsigned VEC_W  = 6;
    localparam int unsigned OUT_W  = 8;
    localparam int unsigned SIG_W  = 16;

    localparam logic [VEC_W-1:0] VEC_LAST     = 6'd63;
    localparam logic [SIG_W-1:0] SIG_SEED_DEF = 16'hFFFF;
    localparam logic [SIG_W-1:0] SIG_POLY_DEF = 16'h1021;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        REPORT,
        DONE
    } state_t;
endpackage

// File: rtl/cell_sweep_ctrl_if.sv
// Page-signature stream: producer drives valid/page/data, consumer drives ready.
interface cell_sweep_ctrl_if;
    import cell_sweep_pkg::*;

    logic              sig_valid;
    logic              sig_ready;
    logic [PAGE_W-1:0] sig_page;
    logic [SIG_W-1:0]  sig_data;

    modport master (output sig_valid, output sig_page, output sig_data, input sig_ready);
    modport slave  (input sig_valid, input sig_page, input sig_data, output sig_ready);
endinterface

// File: rtl/cell_sweep_ctrl_misr.sv
// Combinational next-state of the 16-bit page signature register.
module cell_sweep_misr
    import cell_sweep_pkg::*;
#(
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_POLY_DEF
) (
    input  logic [SIG_W-1:0] sig,
    input  logic [OUT_W-1:0] sample,
    output logic [SIG_W-1:0] sig_next
);
    always_comb begin
        sig_next = {sig[SIG_W-2:0], 1'b0}
                 ^ (sig[SIG_W-1] ? SIG_POLY : '0)
                 ^ {{(SIG_W-OUT_W){1'b0}}, sample};
    end
endmodule

// File: rtl/cell_sweep_ctrl.sv
// Sweep sequencer: drives every vector of each page in range into the cell mux and
// reports one MISR signature per page over the sig_if stream.
module cell_sweep_ctrl
    import cell_sweep_pkg::*;
#(
    parameter int unsigned      SETTLE_CYCLES = 2,
    parameter logic [SIG_W-1:0] SIG_SEED      = SIG_SEED_DEF,
    parameter logic [SIG_W-1:0] SIG_POLY      = SIG_POLY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [PAGE_W-1:0] page_first,
    input  logic [PAGE_W-1:0] page_last,
    input  logic              tri_en,
    output logic [PAGE_W-1:0] cell_page,
    output logic [VEC_W-1:0]  cell_in,
    output logic              cell_tgate,
    input  logic [OUT_W-1:0]  cell_out,
    cell_sweep_ctrl_if.master sig_if,
    output logic              busy,
    output logic              done
);
    localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic [PAGE_W-1:0] last_q;
    logic [SIG_W-1:0]  sig;
    logic [SIG_W-1:0]  sig_next;

    cell_sweep_misr #(.SIG_POLY(SIG_POLY)) u_misr (
        .sig      (sig),
        .sample   (cell_out),
        .sig_next (sig_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            last_q           <= '0;
            sig              <= SIG_SEED;
            cell_page        <= '0;
            cell_in          <= '0;
            cell_tgate       <= 1'b0;
            sig_if.sig_valid <= 1'b0;
            sig_if.sig_page  <= '0;
            sig_if.sig_data  <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            done <= 1'b0;
            // Abort wins over everything, including a handshake in the same cycle.
            if (abort && state != IDLE) begin
                state            <= IDLE;
                sig_if.sig_valid <= 1'b0;
                busy             <= 1'b0;
                cell_tgate       <= 1'b0;
                cell_page        <= '0;
                cell_in          <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            last_q     <= page_last;
                            cell_tgate <= tri_en;
                            cell_page  <= page_first;
                            cell_in    <= '0;
                            sig        <= SIG_SEED;
                            cnt        <= CNT_RELOAD;
                            busy       <= 1'b1;
                            state      <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (cnt == '0) state <= SAMPLE;
                        else           cnt   <= cnt - 4'd1;
                    end
                    SAMPLE: begin
                        sig <= sig_next;
                        if (cell_in == VEC_LAST) begin
                            sig_if.sig_data  <= sig_next;
                            sig_if.sig_page  <= cell_page;
                            sig_if.sig_valid <= 1'b1;
                            state            <= REPORT;
                        end else begin
                            cell_in <= cell_in + 6'd1;
                            cnt     <= CNT_RELOAD;
                            state   <= SETTLE;
                        end
                    end
                    REPORT: begin
                        if (sig_if.sig_ready) begin
                            sig_if.sig_valid <= 1'b0;
                            if (cell_page == last_q) begin
                                cell_tgate <= 1'b0;
                                state      <= DONE;
                            end else begin
                                cell_page <= cell_page + 5'd1;
                                cell_in   <= '0;
                                sig       <= SIG_SEED;
                                cnt       <= CNT_RELOAD;
                                state     <= SETTLE;
                            end
                        end
                    end
                    DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/cell_sweep_ctrl.md
Name: cell_sweep_ctrl

Overview:
- Autonomous sweep sequencer for the cell multiplexer.
- Steps through a configurable range of cell pages and applies all 64 input vectors to each page.
- Waits a programmable settle time after each vector, then samples the 8-bit cell output and folds it into a per-page 16-bit MISR signature.
- Reports each page signature over a valid/ready handshake. Sits between the top-level pin wrapper and the cell multiplexer, and owns its page/in/tristate_gate inputs while busy.

Parameters:
- SETTLE_CYCLES, 2, cycles to hold each vector before sampling; legal range 1..15.
- SIG_SEED, 16'hFFFF, MISR value loaded at the start of every page.
- SIG_POLY, 16'h1021, MISR feedback polynomial.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins a sweep when idle
- abort  in  1  terminates the sweep; returns to IDLE next cycle
- page_first  in  5  first page of the sweep
- page_last  in  5  last page of the sweep (inclusive)
- tri_en  in  1  tristate gate value applied to the mux during the sweep
- cell_page  out  5  page select to the cell multiplexer
- cell_in  out  6  input vector to the cell multiplexer
- cell_tgate  out  1  tristate gate to the cell multiplexer
- cell_out  in  8  cell multiplexer output
- sig_valid  out  1  signature available
- sig_ready  in  1  consumer accepts signature
- sig_page  out  5  page the signature belongs to
- sig_data  out  16  page signature
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at sweep completion

Behaviour:
- Reset: IDLE. Every output is 0; the internal signature register is loaded with SIG_SEED.
- All outputs are registered.
- States: IDLE, SETTLE, SAMPLE, REPORT, DONE.
- IDLE:
  - start=1 and abort=0 latches page_first, page_last and tri_en.
  - Sets cell_page=page_first, cell_in=0, sig=SIG_SEED, settle counter=SETTLE_CYCLES-1, then goes to SETTLE.
  - start while not IDLE is ignored. abort in IDLE has no effect.
- SETTLE: counter decrements each cycle; at 0 go to SAMPLE. Duration is exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle):
  - sig <= {sig[14:0],1'b0} ^ (sig[15] ? SIG_POLY : 0) ^ {8'h00, cell_out}.
  - If cell_in==63: go to REPORT with sig_data = updated sig and sig_page = cell_page.
  - Otherwise: cell_in+1, reload counter, go to SETTLE.
- Per-vector period is SETTLE_CYCLES+1 cycles; per-page period is 64*(SETTLE_CYCLES+1) cycles.
- REPORT:
  - sig_valid=1. sig_data and sig_page are held stable until sig_valid && sig_ready.
  - On handshake, sig_valid drops next cycle.
  - If cell_page==page_last: go to DONE.
  - Otherwise: cell_page = (cell_page+1) mod 32, cell_in=0, sig=SIG_SEED, go to SETTLE.
  - Backpressure stalls the sweep indefinitely; cell_page and cell_in stay frozen.
- DONE: done=1 for one cycle, then IDLE.
- Wrap-around: if page_first > page_last, the sweep wraps 31→0. page_first==page_last sweeps exactly one page. Maximum sweep is 32 pages (page_last = page_first-1 mod 32).
- cell_tgate equals latched tri_en in SETTLE/SAMPLE/REPORT and is 0 in IDLE/DONE.
- abort in any non-IDLE state:
  - Next state is IDLE; sig_valid, busy, cell_tgate, cell_page and cell_in clear to 0.
  - done is not pulsed and no partial signature is emitted.
  - abort outranks a simultaneous sig handshake: the consumed signature counts as delivered but nothing follows.
- Asynchronous reset mid-sweep forces the reset values immediately.

Decomposition:
- Package cell_sweep_pkg holds:
  - state enum (IDLE, SETTLE, SAMPLE, REPORT, DONE)
  - widths PAGE_W=5, VEC_W=6, OUT_W=8, SIG_W=16
  - VEC_LAST=63
  - default SIG_SEED and SIG_POLY
- Sub-module cell_sweep_misr: combinational next-signature function (sig, sample) → sig_next, reused by the bench model.

Test Plan:
- Single page: page_first=page_last=3, SETTLE_CYCLES=2, sig_ready=1, cell_out=cell_in ^ 8'h5A → cell_page=3 throughout; cell_in steps 0..63, each value held 3 cycles; sig_valid rises 192 cycles after the start edge with sig_page=3 and sig_data equal to the cell_sweep_misr model; done pulses 2 cycles later.
- Wrapped range: page_first=30, page_last=1 → four signatures with sig_page 30, 31, 0, 1 in order; each page reseeds to 16'hFFFF (constant cell_out gives four identical signatures).
- Backpressure: sig_ready=0 for 50 cycles during REPORT → sig_valid, sig_data and sig_page stable; cell_in stays 63; sweep resumes on the cycle after sig_ready=1.
- Abort: abort asserted at vector 20 of page 5 → next cycle busy=0, cell_tgate=0, cell_page=0, cell_in=0, no sig_valid, no done; a new start then sweeps cleanly.
- Reset mid-REPORT: rst pulsed while sig_valid=1 → all outputs 0 asynchronously; IDLE after release.
- Start ignored: second start while busy and tri_en toggling → sweep unaffected; cell_tgate keeps the value latched at the first start.
